// File: rtl/cla_pkg.sv
// Shared types and defaults for the chunked carry-lookahead adder.
// Holds the FSM encoding, default geometry and the lookahead carry helper.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  // Flat sum-of-products carry into position n: G[n-1] | P[n-1]G[n-2] | ... | P..P0 c0
  function automatic logic cla_carry(
    input logic [63:0] g,
    input logic [63:0] p,
    input logic        c0,
    input int          n
  );
    logic r;
    logic pr;
    r  = 1'b0;
    pr = 1'b1;
    for (int i = 63; i >= 0; i--) begin
      if (i < n) begin
        r  = r | (pr & g[i]);
        pr = pr & p[i];
      end
    end
    return r | (pr & c0);
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational CHUNK-bit two-level carry-lookahead adder.
// Bits form 4-bit groups with group P/G; group carries come from one lookahead level.
module cla_chunk
  import cla_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  localparam int unsigned NG = CHUNK / 4;

  if ((CHUNK % 4) != 0 || CHUNK < 4 || CHUNK > 256) begin : g_bad_chunk
    $error("cla_chunk: CHUNK must be a multiple of 4 in 4..256");
  end

  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] bc;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [NG:0]      gc;

  assign p = x ^ y;
  assign g = x & y;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    logic [3:0] pg;
    logic [3:0] gg;
    assign pg       = p[4*j +: 4];
    assign gg       = g[4*j +: 4];
    assign grp_p[j] = &pg;
    assign grp_g[j] = cla_carry(64'(gg), 64'(pg), 1'b0, 4);
    for (genvar b = 0; b < 4; b++) begin : g_bit
      assign bc[4*j+b] = cla_carry(64'(gg), 64'(pg), gc[j], b);
    end
  end

  for (genvar j = 0; j <= NG; j++) begin : g_gc
    assign gc[j] = cla_carry(64'(grp_g), 64'(grp_p), ci, j);
  end

  assign s     = p ^ bc;
  assign co    = gc[NG];
  assign c_msb = bc[CHUNK-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Sequential adder resolving CHUNK bits per cycle with a lookahead chunk adder.
// Define CLA_SUB_EN to add the sub port (a + ~b + 1, cin ignored).
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((WIDTH % CHUNK) != 0 || (CHUNK % 4) != 0 || WIDTH < CHUNK) begin : g_bad_cfg
    $error("cla_seq_adder: need WIDTH%%CHUNK==0, CHUNK%%4==0, WIDTH>=CHUNK");
  end

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             sub_eff;
  logic             accept;
  logic             last;
  logic [CHUNK-1:0] ch_s;
  logic             ch_co;
  logic             ch_msb;

`ifdef CLA_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last      = (k_q == KW'(NCH - 1));
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  cla_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x     (a_q[k_q*CHUNK +: CHUNK]),
    .y     (b_q[k_q*CHUNK +: CHUNK]),
    .ci    (carry_q),
    .s     (ch_s),
    .co    (ch_co),
    .c_msb (ch_msb)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: ;
      CALC: begin
        sum_d[k_q*CHUNK +: CHUNK] = ch_s;
        carry_d = ch_co;
        k_d     = k_q + 1'b1;
        if (last) begin
          state_d = DONE;
          k_d     = '0;
          cout_d  = ch_co;
          ovf_d   = ch_msb ^ ch_co;
          zero_d  = (sum_d == '0);
        end
      end
      DONE: begin
        if (out_ready & ~in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Subtraction folds into the operand: invert b and force the carry-in.
    if (accept) begin
      state_d = CALC;
      k_d     = '0;
      a_d     = a;
      b_d     = sub_eff ? ~b : b;
      carry_d = sub_eff | cin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: directed corners plus random traffic
// checked against a plain-arithmetic reference model.
module tb_cla_seq_adder;

  localparam int W   = 32;
  localparam int C   = 8;
  localparam int NCH = W / C;

  typedef struct packed {
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [W-1:0] sum;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic         sub_i = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf, zero;
  logic [W-1:0] sum;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  int   n_res = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                 logic c, logic s);
    exp_t         r;
    logic [W-1:0] yy;
    logic [W:0]   full;
    yy     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, yy} + (W+1)'(s ? 1'b1 : c);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    r.zero = (full[W-1:0] == '0);
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(7))
      0: v = '0;
      1: v = '1;
      2: v = 32'h7FFF_FFFF;
      3: v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Call just after a falling edge; acceptance happens at the next rising edge.
  task automatic drive(logic [W-1:0] x, logic [W-1:0] y, logic c, logic s,
                       output bit acc);
    a        = x;
    b        = y;
    cin      = c;
    sub_i    = s;
    in_valid = 1'b1;
    #1;
    acc = in_ready;
    if (acc) begin
      exp_q.push_back(model(x, y, c, s));
      n_acc++;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic directed(string nm, logic [W-1:0] x, logic [W-1:0] y,
                          logic c, logic s, logic [W-1:0] es,
                          logic ec, logic eo, logic ez);
    bit acc;
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    drive(x, y, c, s, acc);
    chk({nm, "_accept"}, 64'(acc), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    cin = 1'b1;
    wait_valid(lat);
    chk({nm, "_latency"}, 64'(lat), 64'(NCH));
    chk({nm, "_sum"}, 64'(sum), 64'(es));
    chk({nm, "_flags"}, 64'({cout, ovf, zero}), 64'({ec, eo, ez}));
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      n_res++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(sum), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", 64'({cout, ovf, zero, sum}), 64'(e));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           acc;
    int           lat;
    int           cyc;
    int           base;
    logic [63:0]  snap;
    logic         s;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_outputs", 64'({sum, cout, ovf, zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    directed("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0,
             32'h0, 1'b1, 1'b0, 1'b1);
    directed("ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("cin", 32'h0000_00FF, 32'h0000_FF00, 1'b1, 1'b0,
             32'h0001_0000, 1'b0, 1'b0, 1'b0);
`ifdef CLA_SUB_EN
    directed("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1,
             32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1,
             32'd2, 1'b1, 1'b0, 1'b0);
`endif

    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, acc);
    chk("hold_accept", 64'(acc), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("hold_latency", 64'(lat), 64'(NCH));
    snap = 64'({cout, ovf, zero, sum});
    repeat (10) begin
      @(negedge clk);
      a = $urandom;
      #1;
      chk("hold_outputs", 64'({cout, ovf, zero, sum}), snap);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    drive(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, acc);
    chk("b2b_accept", 64'(acc), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("b2b_latency", 64'(lat), 64'(NCH));

    repeat (2) @(negedge clk);
    drive(32'hAAAA_5555, 32'h1111_2222, 1'b0, 1'b0, acc);
    chk("rst_accept", 64'(acc), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    exp_q.delete();
    n_acc--;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #1;
      chk("rst_no_result", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
    end

    base = n_acc;
    cyc  = 0;
    while (n_acc < base + 10000 && cyc < 90000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(3) != 0);
`ifdef CLA_SUB_EN
      s = 1'($urandom_range(1));
`else
      s = 1'b0;
`endif
      if ($urandom_range(3) != 0) begin
        drive(pick(), pick(), 1'($urandom_range(1)), s, acc);
      end else begin
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
      end
    end
    chk("random_accepts", 64'(n_acc - base), 64'd10000);

    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    chk("result_count", 64'(n_res), 64'(n_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
